// File: rtl/exp_scale_bf16_if.sv
// Valid/ready bundle between the exp polynomial stage, the scaler and its consumer.
// The master side drives inputs and out_ready; the slave side is the scaler.
interface exp_scale_bf16_if #(
   parameter int SCALE_W = 9
);
   logic               in_valid;
   logic               in_ready;
   logic [15:0]        in_data;
   logic [SCALE_W-1:0] in_scale;
   logic               out_valid;
   logic               out_ready;
   logic [15:0]        out_data;

   modport master (
      output in_valid, in_data, in_scale, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_scale, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/exp_scale_bf16.sv
// BF16 2^k * p scaler: 2-stage exponent pipeline feeding a credit-managed FIFO.
// Define EXP_SCALE_SUBNORM_EN to emit rounded subnormals instead of flushing.
module exp_scale_bf16 #(
   parameter int SCALE_W    = 9,
   parameter int FIFO_DEPTH = 4
) (
   input logic            clk,
   input logic            rst,
   exp_scale_bf16_if.slave bus
);
   localparam int EW = SCALE_W + 2;
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {C_NORM, C_ZERO, C_INF, C_NAN} cls_t;

   localparam logic signed [EW-1:0] E_MAX = EW'(255);
   localparam logic signed [EW-1:0] E_MIN = '0;

   logic                 v1;
   logic                 s1;
   logic [6:0]           m1;
   cls_t                 c1;
   logic signed [EW-1:0] ep1;
   logic                 v2;
   logic [15:0]          d2;

   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW+1:0] used;
   logic          take;
   logic          pop;

   logic [7:0]           e_in;
   logic [6:0]           m_in;
   cls_t                 c_in;
   logic signed [EW-1:0] ep_in;
   logic [15:0]          pack;

   // Credit counts everything in flight so S2 can always push.
   assign used = {1'b0, count}
               + {{(AW+1){1'b0}}, v1}
               + {{(AW+1){1'b0}}, v2};
   assign bus.in_ready  = !rst && (used < (AW+2)'(FIFO_DEPTH));
   assign take          = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (count != '0);
   assign pop           = bus.out_valid && bus.out_ready;
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : 16'h0000;

   assign e_in  = bus.in_data[14:7];
   assign m_in  = bus.in_data[6:0];
   assign ep_in = $signed({{(EW-8){1'b0}}, e_in})
                + $signed({{2{bus.in_scale[SCALE_W-1]}}, bus.in_scale});

   always_comb begin
      c_in = C_NORM;
      if (e_in == 8'hFF) c_in = (m_in != '0) ? C_NAN : C_INF;
      else if (e_in == 8'h00) c_in = C_ZERO;
   end

`ifdef EXP_SCALE_SUBNORM_EN
   localparam logic signed [EW-1:0] E_SUB = -EW'(7);
   logic [3:0]  sh;
   logic [15:0] sx;
   logic [7:0]  mq;
   logic        rup;
   logic [15:0] sub;

   // Guard is the first dropped bit; ties go to the even mantissa.
   always_comb begin
      sh  = 4'd1 - ep1[3:0];
      sx  = {1'b1, m1, 8'h00} >> sh;
      mq  = sx[15:8];
      rup = sx[7] && ((|sx[6:0]) || mq[0]);
      sub = (ep1 >= E_SUB) ? {s1, 7'h00, mq + 8'(rup)} : {s1, 15'h0};
   end
`else
   logic [15:0] sub;
   assign sub = {s1, 15'h0};
`endif

   always_comb begin
      pack = {s1, ep1[7:0], m1};
      if (c1 == C_NAN) pack = 16'h7FC0;
      else if (c1 == C_INF) pack = {s1, 8'hFF, 7'h00};
      else if (c1 == C_ZERO) pack = {s1, 15'h0};
      else if (ep1 >= E_MAX) pack = {s1, 8'hFF, 7'h00};
      else if (ep1 <= E_MIN) pack = sub;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1  <= 1'b0;
         s1  <= 1'b0;
         m1  <= '0;
         c1  <= C_NORM;
         ep1 <= '0;
         v2  <= 1'b0;
         d2  <= '0;
      end else begin
         v1 <= take;
         v2 <= v1;
         if (take) begin
            s1  <= bus.in_data[15];
            m1  <= m_in;
            c1  <= c_in;
            ep1 <= ep_in;
         end
         if (v1) d2 <= pack;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (v2) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         unique case ({v2, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (v2) mem[wr_ptr] <= d2;
   end
endmodule

// File: tb/tb_exp_scale_bf16.sv
// Directed bench for exp_scale_bf16 with a queue scoreboard on the output.
// Expected underflow values follow EXP_SCALE_SUBNORM_EN when it is defined.
module tb_exp_scale_bf16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   pops  = 0;
   int   p0;
   int   acc;
   logic [15:0] sb [$];
   logic [15:0] st_exp [8] = '{16'h3E00, 16'h3E80, 16'h3F00, 16'h3F80,
                               16'h4000, 16'h4080, 16'h4100, 16'h4180};
   logic [15:0] bp_exp [8] = '{16'h4040, 16'h40C0, 16'h4140, 16'h41C0,
                               16'h4240, 16'h42C0, 16'h4340, 16'h43C0};

   always #5 clk = ~clk;

   exp_scale_bf16_if #(.SCALE_W(9)) bus ();

   exp_scale_bf16 #(.SCALE_W(9), .FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         pops++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty obs=%0h exp=none", bus.out_data);
         end else begin
            check("out_data", bus.out_data, sb.pop_front());
         end
      end
   end

   task automatic send(input logic [15:0] p, input int k,
                       input logic [15:0] e);
      logic ok = 1'b0;
      bus.in_data  = p;
      bus.in_scale = 9'(k);
      bus.in_valid = 1'b1;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
      end
      check("send_accept", {31'b0, ok}, 1);
      if (ok) sb.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      logic done = 1'b0;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.out_valid) done = 1'b1;
      end
      check("drain_left", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_scale  = '0;
      bus.out_ready = 1'b0;
      #12;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_in_ready", bus.in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready", bus.in_ready, 1);

      bus.out_ready = 1'b1;
      send(16'h3F80, 3, 16'h4100);
      send(16'hBFC0, -2, 16'hBEC0);
      send(16'h7F00, 1, 16'h7F80);
      send(16'h3F80, 200, 16'h7F80);
      send(16'h7FC1, 5, 16'h7FC0);
      send(16'hFFC1, -9, 16'h7FC0);
      send(16'hFF80, 3, 16'hFF80);
      send(16'h8001, 5, 16'h8000);
      send(16'h3F80, -126, 16'h0080);
      send(16'hC000, -136, 16'h8000);
`ifdef EXP_SCALE_SUBNORM_EN
      send(16'h3F80, -127, 16'h0040);
      send(16'h3FC0, -133, 16'h0002);
`else
      send(16'h3F80, -127, 16'h0000);
      send(16'h3FC0, -133, 16'h0000);
`endif
      drain();

      p0 = pops;
      for (int i = 0; i < 8; i++) begin
         bus.in_data  = 16'h3F80;
         bus.in_scale = 9'(i - 3);
         bus.in_valid = 1'b1;
         @(negedge clk);
         check("stream_ready", bus.in_ready, 1);
         check("lat_valid", bus.out_valid, (i >= 3) ? 1 : 0);
         sb.push_back(st_exp[i]);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("thru_valid", bus.out_valid, 1);
      end
      @(negedge clk);
      check("thru_end", bus.out_valid, 0);
      @(posedge clk);
      #1;
      drain();
      check("stream_pops", pops - p0, 8);

      bus.out_ready = 1'b0;
      acc = 0;
      p0 = pops;
      for (int c = 0; c < 10; c++) begin
         bus.in_data  = 16'h4040;
         bus.in_scale = 9'(acc);
         bus.in_valid = 1'b1;
         @(negedge clk);
         if (bus.in_ready && acc < 8) begin
            sb.push_back(bp_exp[acc]);
            acc++;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      check("bp_accepts", acc, 4);
      @(negedge clk);
      check("bp_ready_low", bus.in_ready, 0);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_data", bus.out_data, 16'h4040);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain();
      check("bp_pops", pops - p0, 4);
      check("bp_ready_back", bus.in_ready, 1);

      bus.out_ready = 1'b0;
      send(16'h3F80, 1, 16'h4000);
      send(16'h3F80, 2, 16'h4080);
      send(16'h3F80, 4, 16'h4180);
      repeat (3) @(posedge clk);
      #3;
      check("pre_rst_head", bus.out_data, 16'h4000);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_data", bus.out_data, 0);
      check("mid_rst_ready", bus.in_ready, 0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rel_ready", bus.in_ready, 1);
      check("rel_no_stale", bus.out_valid, 0);
      bus.out_ready = 1'b1;
      p0 = pops;
      send(16'h3F80, 3, 16'h4100);
      drain();
      check("rel_pops", pops - p0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
